// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int DEPTH_DEFAULT  = 256;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_IDX_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Collects stream bytes little-endian into one bundle word and keeps the
// running XOR checksum of every accepted byte.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [7:0]                    byte_data,
  output logic [8*BYTES_PER_WORD-1:0]   word,
  output logic                          last,
  output logic [7:0]                    csum
);

  logic [LANE_IDX_W-1:0]        byte_idx;
  logic [8*BYTES_PER_WORD-1:0]  lanes;

  // word already contains the byte being accepted this cycle, so the caller
  // can capture a complete bundle on the same edge as the final transfer.
  always_comb begin
    word = lanes;
    if (accept) begin
      word[{byte_idx, 3'b000} +: 8] = byte_data;
    end
  end

  assign last = (byte_idx == LANE_IDX_W'(BYTES_PER_WORD - 1));

  // byte_idx wraps to zero after the final lane, so no separate word clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      lanes    <= '0;
      csum     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      lanes    <= '0;
      csum     <= '0;
    end else if (accept) begin
      lanes    <= word;
      byte_idx <= byte_idx + 1'b1;
      csum     <= csum ^ byte_data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: fills instruction memory from a byte stream and releases
// the core from reset once the trailing XOR checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             im_we,
  output logic [31:0]      im_addr,
  output logic [31:0]      im_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  loader_state_t    state, state_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] word_idx;

  logic        pk_clear;
  logic        pk_accept;
  logic        pk_last;
  logic [31:0] pk_word;
  logic [7:0]  pk_csum;
  logic        csum_xfer;

  imem_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .byte_data (byte_data),
    .word      (pk_word),
    .last      (pk_last),
    .csum      (pk_csum)
  );

  always_comb begin
    state_n   = state;
    pk_clear  = 1'b0;
    pk_accept = (state == RECV) && byte_valid && byte_ready;
    csum_xfer = (state == CSUM) && byte_valid && byte_ready;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          if (num_words == '0 || num_words > DEPTH_C) begin
            state_n = ERR;
          end else begin
            state_n  = RECV;
            pk_clear = 1'b1;
          end
        end
      end
      RECV: begin
        if (pk_accept && pk_last) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        state_n = (word_idx + 1'b1 == count) ? CSUM : RECV;
      end
      CSUM: begin
        if (csum_xfer) begin
          state_n = (byte_data == pk_csum) ? DONE : ERR;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state, so they line up with
  // the state register and never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      byte_ready <= (state_n == RECV) || (state_n == CSUM);
      im_we      <= (state_n == WRITE);
      done       <= (state_n == DONE);
      error      <= (state_n == ERR);
      cpu_hold   <= (state_n != DONE);

      if (pk_clear) begin
        count    <= num_words;
        word_idx <= '0;
      end else if (state == WRITE) begin
        word_idx <= word_idx + 1'b1;
      end

      if (state == RECV && state_n == WRITE) begin
        im_addr  <= 32'({word_idx, 2'b00});
        im_wdata <= pk_word;
      end
    end
  end

endmodule
